// File: rtl/eqn_chk_pkg.sv
// eqn_chk_pkg: shared state encoding and the "no mismatch" index constant
package eqn_chk_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
   function automatic logic [63:0] idx_none(int w);
      return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
   endfunction
endpackage

// File: rtl/eqn_mask_cmp.sv
// eqn_mask_cmp: combinational masked W-bit equality
module eqn_mask_cmp #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] mask,
   output logic         eq
);
   assign eq = ((a ^ b) & mask) == '0;
endmodule

// File: rtl/eqn_stream_checker.sv
// eqn_stream_checker: masked compare of an operand stream with run statistics
module eqn_stream_checker #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop_on_miss,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             in_valid,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [W-1:0]     mask,
   output logic             aeqb,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] miss_cnt,
   output logic [CNT_W-1:0] first_miss_idx,
   output logic             any_miss
);
   import eqn_chk_pkg::*;
   localparam logic [CNT_W-1:0] IDX_NONE = CNT_W'(idx_none(CNT_W));
   state_t state, state_n;
   logic eq, accept, last, begin_run, stop_q;
   logic [CNT_W-1:0] num_q, vec_idx;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == IDX_NONE) ? v : v + CNT_W'(1);
   endfunction
   eqn_mask_cmp #(.W(W)) u_cmp (.a(a), .b(b), .mask(mask), .eq(eq));
   assign accept    = (state == RUN) && in_valid;
   // widened by one bit so num_vec = max cannot wrap the comparison
   assign last      = ({1'b0, vec_idx} + (CNT_W+1)'(1)) == {1'b0, num_q};
   assign begin_run = start && (state != RUN);
   assign busy      = state == RUN;
   assign done      = state == DONE;
   always_comb
      state_n = begin_run ? ((num_vec == '0) ? DONE : RUN)
              : (accept && (last || (!eq && stop_q))) ? DONE : state;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         aeqb           <= 1'b0;
         out_valid      <= 1'b0;
         match_cnt      <= '0;
         miss_cnt       <= '0;
         first_miss_idx <= IDX_NONE;
         any_miss       <= 1'b0;
         vec_idx        <= '0;
         num_q          <= '0;
         stop_q         <= 1'b0;
      end else begin
         out_valid <= accept;
         if (accept) aeqb <= eq;
         if (begin_run) begin
            num_q          <= num_vec;
            stop_q         <= stop_on_miss;
            match_cnt      <= '0;
            miss_cnt       <= '0;
            first_miss_idx <= IDX_NONE;
            any_miss       <= 1'b0;
            vec_idx        <= '0;
         end else if (accept) begin
            vec_idx <= sat_inc(vec_idx);
            if (eq) match_cnt <= sat_inc(match_cnt);
            else begin
               miss_cnt <= sat_inc(miss_cnt);
               if (!any_miss) begin
                  first_miss_idx <= vec_idx;
                  any_miss       <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_eqn_stream_checker.sv
// tb_eqn_stream_checker: randomized scoreboard bench against a run-level model
module tb_eqn_stream_checker;
   logic clk = 1'b0, reset_n, start, stop_on_miss, in_valid, start4;
   logic [15:0] num_vec;
   logic [3:0] num4;
   logic [7:0] a, b, mask;
   logic aeqb, out_valid, busy, done, any_miss;
   logic [15:0] match_cnt, miss_cnt, first_miss_idx;
   logic aeqb4, out_valid4, busy4, done4, any_miss4;
   logic [3:0] match4, miss4, first4;
   int vectors = 0, miscompares = 0;
   bit sb[$];
   bit e;
   bit m_run, m_done, m_stop, m_any;
   int m_idx, m_num, m_match, m_miss, m_first;
   logic [7:0] pa [7] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
   logic [7:0] pb [7] = '{8'd0, 8'd0, 8'd3, 8'd2, 8'd0, 8'd3, 8'd1};

   always #5 clk = ~clk;

   eqn_stream_checker #(.W(8), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop_on_miss(stop_on_miss),
      .num_vec(num_vec), .in_valid(in_valid), .a(a), .b(b), .mask(mask),
      .aeqb(aeqb), .out_valid(out_valid), .busy(busy), .done(done),
      .match_cnt(match_cnt), .miss_cnt(miss_cnt), .first_miss_idx(first_miss_idx),
      .any_miss(any_miss));

   eqn_stream_checker #(.W(8), .CNT_W(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .stop_on_miss(stop_on_miss),
      .num_vec(num4), .in_valid(in_valid), .a(a), .b(b), .mask(mask),
      .aeqb(aeqb4), .out_valid(out_valid4), .busy(busy4), .done(done4),
      .match_cnt(match4), .miss_cnt(miss4), .first_miss_idx(first4),
      .any_miss(any_miss4));

   always @(negedge clk)
      if (reset_n && out_valid) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_out_valid aeqb=%0b, no result was pending", aeqb);
         end else begin
            e = sb.pop_front();
            if (aeqb !== e) begin
               miscompares++;
               $display("FAIL aeqb got=%0b want=%0b", aeqb, e);
            end
         end
      end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_done = 0; m_stop = 0; m_any = 0;
      m_idx = 0; m_num = 0; m_match = 0; m_miss = 0; m_first = 'hFFFF;
   endtask

   task automatic do_start(input int n, input bit st);
      start = 1'b1; num_vec = 16'(n); stop_on_miss = st; in_valid = 1'b0;
      if (!m_run) begin
         m_num = n; m_stop = st; m_idx = 0; m_match = 0; m_miss = 0;
         m_first = 'hFFFF; m_any = 0; m_run = (n != 0); m_done = (n == 0);
      end
      cyc();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vm);
      bit eqm;
      a = va; b = vb; mask = vm; in_valid = 1'b1;
      if (m_run) begin
         eqm = ((va ^ vb) & vm) == 0;
         sb.push_back(eqm);
         if (eqm) m_match++;
         else begin
            m_miss++;
            if (!m_any) begin m_first = m_idx; m_any = 1; end
         end
         m_idx++;
         if (m_idx == m_num || (!eqm && m_stop)) begin m_run = 0; m_done = 1; end
      end
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_match_cnt"}, 32'(match_cnt), 32'(m_match));
      chk({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(m_miss));
      chk({tag, "_first_miss_idx"}, 32'(first_miss_idx), 32'(m_first));
      chk({tag, "_any_miss"}, 32'(any_miss), 32'(m_any));
      chk({tag, "_busy"}, 32'(busy), 32'(m_run));
      chk({tag, "_done"}, 32'(done), 32'(m_done));
   endtask

   initial begin
      reset_n = 1'b0; start = 0; start4 = 0; stop_on_miss = 0; in_valid = 0;
      num_vec = 0; num4 = 0; a = 0; b = 0; mask = 0;
      model_reset();
      idle(2);
      reset_n = 1'b1;
      idle(1);
      // mid-run reset
      do_start(10, 0);
      send(8'h11, 8'h11, 8'hFF);
      send(8'h11, 8'h10, 8'hFF);
      idle(2);
      reset_n = 1'b0;
      #2;
      model_reset();
      chk("rst_aeqb", 32'(aeqb), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_first_miss_idx", 32'(first_miss_idx), 32'hFFFF);
      check_status("rst");
      idle(1);
      reset_n = 1'b1;
      idle(1);
      send(8'h33, 8'h33, 8'hFF);
      send(8'h44, 8'h44, 8'hFF);
      chk("idle_no_out_valid", 32'(out_valid), 0);
      // full match run
      do_start(4, 0);
      send(8'h00, 8'h00, 8'hFF);
      send(8'h5A, 8'h5A, 8'hFF);
      send(8'hFF, 8'hFF, 8'hFF);
      send(8'h01, 8'h01, 8'hFF);
      chk("full_done", 32'(done), 1);
      idle(1);
      check_status("full");
      chk("full_match_const", 32'(match_cnt), 4);
      // mixed run without stop
      do_start(7, 0);
      for (int i = 0; i < 7; i++) send(pa[i], pb[i], 8'hFF);
      idle(1);
      check_status("mixed");
      chk("mixed_match_const", 32'(match_cnt), 3);
      chk("mixed_miss_const", 32'(miss_cnt), 4);
      chk("mixed_first_const", 32'(first_miss_idx), 1);
      // stop on miss, remaining vectors must be ignored
      do_start(7, 1);
      send(pa[0], pb[0], 8'hFF);
      send(pa[1], pb[1], 8'hFF);
      chk("stop_done", 32'(done), 1);
      for (int i = 2; i < 7; i++) send(pa[i], pb[i], 8'hFF);
      idle(1);
      check_status("stop");
      chk("stop_match_const", 32'(match_cnt), 1);
      chk("stop_miss_const", 32'(miss_cnt), 1);
      // mask handling
      do_start(3, 0);
      send(8'hF0, 8'h0F, 8'h00);
      send(8'hF0, 8'h0F, 8'h01);
      send(8'hA5, 8'hA4, 8'hFE);
      idle(1);
      check_status("mask");
      // empty run
      do_start(0, 0);
      chk("empty_done", 32'(done), 1);
      check_status("empty");
      // start during RUN with in_valid gaps
      do_start(5, 0);
      send(8'h01, 8'h01, 8'hFF);
      idle(1);
      do_start(2, 1);
      send(8'h02, 8'h03, 8'hFF);
      idle(2);
      send(8'h04, 8'h04, 8'hFF);
      do_start(1, 0);
      send(8'h05, 8'h07, 8'hFF);
      idle(1);
      send(8'h06, 8'h06, 8'hFF);
      idle(1);
      check_status("restart_ignored");
      // randomized runs
      for (int r = 0; r < 12; r++) begin
         do_start($urandom_range(1, 25), 1'($urandom_range(0, 1)));
         for (int k = 0; k < 300 && m_run; k++) begin
            logic [7:0] ra, rm;
            ra = 8'($urandom); rm = 8'($urandom);
            case ($urandom_range(0, 7))
               0: idle(1);
               1: do_start($urandom_range(1, 25), 1'($urandom_range(0, 1)));
               2, 3: send(ra, 8'($urandom), rm);
               default: send(ra, ra ^ (8'($urandom) & ~rm), rm);
            endcase
         end
         idle(1);
         check_status("random");
      end
      // narrow counters: run length of 15 ends the run despite 20 offered vectors
      start4 = 1'b1; num4 = 4'd15;
      cyc();
      start4 = 1'b0;
      for (int i = 0; i < 20; i++) send(8'(i), 8'(i), 8'hFF);
      idle(1);
      chk("cnt4_match", 32'(match4), 15);
      chk("cnt4_miss", 32'(miss4), 0);
      chk("cnt4_first", 32'(first4), 32'hF);
      chk("cnt4_done", 32'(done4), 1);
      chk("cnt4_busy", 32'(busy4), 0);
      idle(2);
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/eqn_stream_checker.md
Name: eqn_stream_checker

Overview:
- Parametrised, sequential successor to the 2-bit equality comparator.
- Compares a stream of W-bit operand pairs under a per-bit mask and registers the per-vector result.
- Accumulates match/miss statistics over a run of a programmed length and captures the index of the first mismatch.
- Sits between a test-vector source (or datapath tap) and a status/LED readout; used for self-checking prototypes.

Parameters:
- W, 8: operand width in bits (W >= 1).
- CNT_W, 16: width of vector/match/miss counters and the index registers.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE or DONE only).
- stop_on_miss  in  1  sampled at start; when 1, the run ends at the first mismatch.
- num_vec  in  CNT_W  run length in vectors, sampled at start; 0 means an empty run.
- in_valid  in  1  operand pair valid this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- mask  in  W  compare enable per bit; 1 = compare, 0 = ignore.
- aeqb  out  1  registered result for the last accepted vector.
- out_valid  out  1  one-cycle pulse, aligned with aeqb.
- busy  out  1  high in RUN.
- done  out  1  high in DONE, held until the next start.
- match_cnt  out  CNT_W  count of matching vectors in the current run.
- miss_cnt  out  CNT_W  count of mismatching vectors in the current run.
- first_miss_idx  out  CNT_W  0-based index of the first mismatch; all-ones if there is none.
- any_miss  out  1  set when any mismatch has occurred in the run.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE.
  - aeqb=0, out_valid=0, busy=0, done=0.
  - match_cnt=0, miss_cnt=0, any_miss=0.
  - first_miss_idx = all-ones; internal vec_idx=0.
- Compare: eq = ((a ^ b) & mask) == 0.
  - mask = 0 forces a match.
  - Combinational compare, registered output: aeqb and out_valid appear 1 cycle after the accepting edge.
- FSM states IDLE, RUN, DONE.
  - IDLE: in_valid ignored, no out_valid. On start: latch num_vec/stop_on_miss, clear counters/any_miss, first_miss_idx = all-ones, vec_idx=0.
    - Go to RUN if num_vec != 0.
    - Go directly to DONE if num_vec == 0.
  - RUN: each cycle with in_valid=1 accepts one vector, increments vec_idx, and increments match_cnt or miss_cnt.
    - On the first miss: first_miss_idx = vec_idx (pre-increment), any_miss=1.
    - Go to DONE on the cycle the last vector is accepted (vec_idx+1 == num_vec).
    - Also go to DONE on a miss when stop_on_miss=1.
  - DONE: done=1, counters frozen, in_valid ignored. start begins a new run (same actions as in IDLE).
- start asserted in RUN is ignored; the run is not restarted.
- The vector accepted on the final RUN cycle still produces out_valid/aeqb on the following cycle (while in DONE).
- Counters saturate at 2^CNT_W-1. They never wrap, including vec_idx; saturation of vec_idx with num_vec = max still terminates correctly.
- Reset mid-run aborts immediately to the reset values; no partial status is retained.
- in_valid gaps in RUN are allowed; there is no timeout.

Decomposition:
- Shared package eqn_chk_pkg: state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the IDX_NONE all-ones constant function of CNT_W.
- One sub-module, eqn_mask_cmp: purely combinational masked W-bit equality.
- FSM, counters and output registers stay in the top.

Test Plan:
- Reset check: hold reset_n=0 mid-run (W=8) -> all outputs at reset values, first_miss_idx=16'hFFFF, state IDLE. Release, then in_valid with a=b -> no out_valid.
- Full match run: start, num_vec=4, vectors (00,00),(5A,5A),(FF,FF),(01,01), mask=FF -> four out_valid pulses with aeqb=1; match_cnt=4, miss_cnt=0, any_miss=0, first_miss_idx=FFFF; done=1 one cycle after the 4th accept.
- Mixed run, stop_on_miss=0: num_vec=7 with a sequence of 2-bit patterns zero-extended (00/00, 01/00, 01/11, 10/10, 10/00, 11/11, 11/01) -> match_cnt=3, miss_cnt=4, first_miss_idx=1.
- Stop on miss: same stream, stop_on_miss=1 -> DONE after vector index 1; match_cnt=1, miss_cnt=1. Further in_valid is ignored and the counters stay frozen.
- Mask: a=8'hF0, b=8'h0F, mask=8'h00 -> aeqb=1. mask=8'h01 -> aeqb=0. a=8'hA5, b=8'hA4, mask=8'hFE -> aeqb=1.
- Edge cases: num_vec=0 -> DONE the cycle after start, counters 0. start pulsed during RUN with in_valid gaps -> run continues and the counts are unaffected. CNT_W=4 with 20 matching vectors and num_vec=15 -> match_cnt=15, done.
